// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state enum
//   - byte-lane strobe base patterns (shifted by the address offset)
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational alignment helpers for the load/store unit.
// Request side (from the live request inputs):
//   is_load, funct3, offset, store_data -> bad (illegal funct3 or misaligned),
//   wstrb (byte-lane strobes for a store), wdata (store data replicated into lanes)
// Load side (from the registered access description and the bus read word):
//   ld_funct3, ld_offset, rdata -> ld_value (selected lane, sign/zero extended)
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic        bad,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] ld_value
);

    logic        legal;
    logic        misaligned;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        wstrb      = 4'b0000;
        wdata      = store_data;
        case (funct3)
            F3_B: begin
                legal = 1'b1;
                wstrb = STRB_B << offset;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                legal      = 1'b1;
                misaligned = offset[0];
                wstrb      = STRB_H << offset;
                wdata      = {2{store_data[15:0]}};
            end
            F3_W: begin
                legal      = 1'b1;
                misaligned = (offset != 2'b00);
                wstrb      = STRB_W;
            end
            // Unsigned widths exist only for loads.
            F3_BU: begin
                legal = is_load;
            end
            F3_HU: begin
                legal      = is_load;
                misaligned = offset[0];
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        bad = !legal || misaligned;
    end

    // Byte lane comes from shifting the word down by 8*offset; halfword lane
    // only depends on offset[1] because aligned halves sit at 0 or 2.
    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_value = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_value = {24'h000000, lane_b};
            F3_H:    ld_value = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_value = {16'h0000, lane_h};
            default: ld_value = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: multicycle load/store unit between execute and data memory.
// Inputs : clk, rst_n (sync, active-low), start, is_load, is_store, funct3,
//          addr, store_data (all sampled with start), mem_ready, mem_rdata.
// Outputs: load_result (held until the next successful load), done (1-cycle
//          pulse), fault (valid with done), busy (state != IDLE), and the bus
//          request group mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata.
// Bus handshake: mem_req rises the cycle after an accepted start and stays
// high, with mem_we/mem_addr/mem_wstrb/mem_wdata frozen, until a cycle in which
// mem_ready is high; that cycle completes the access (mem_rdata is taken then
// for loads). mem_ready in any other cycle is ignored.
// Every output is a register.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_result,
    output logic              done,
    output logic              fault,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    state_t      state;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        req_bad;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] ld_value;

    lsu_align u_align (
        .is_load    (is_load),
        .funct3     (funct3),
        .offset     (addr[1:0]),
        .store_data (store_data),
        .bad        (req_bad),
        .wstrb      (req_wstrb),
        .wdata      (req_wdata),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rdata      (mem_rdata),
        .ld_value   (ld_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ld_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            load_result <= 32'h0;
            done        <= 1'b0;
            fault       <= 1'b0;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wstrb   <= 4'b0000;
            mem_wdata   <= 32'h0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && (is_load || is_store)) begin
                        // A simultaneous load+store is treated as a load.
                        ld_q  <= is_load;
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        busy  <= 1'b1;
                        if (req_bad) begin
                            state <= S_FAULT;
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= !is_load;
                            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb <= is_load ? 4'b0000 : req_wstrb;
                            mem_wdata <= is_load ? 32'h0 : req_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                        if (ld_q) begin
                            load_result <= ld_value;
                        end
                    end
                end
                S_DONE: begin
                    // done was raised on entry; this cycle is the pulse.
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    // One bus-free cycle, then the done+fault pulse leaving
                    // for IDLE, so faults report with the same 2-cycle latency
                    // as the fastest bus access.
                    done  <= 1'b1;
                    fault <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_result;
    logic        done;
    logic        fault;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_lr;

    // Observations from the most recent run_access call.
    bit          o_saw_req;
    logic [68:0] o_req_vec;
    bit          o_stable;
    logic        o_busy1;
    int          o_done_cyc;
    int          o_n_done;
    logic        o_fault;
    logic [31:0] o_lr;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .load_result (load_result),
        .done        (done),
        .fault       (fault),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    // ---------------- reference model (access semantics) ----------------
    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit ld, input logic [2:0] f3, input logic [1:0] off);
        bit ok;
        if (ld) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    ok = (f3 <= 3'd2);
        return ok && ((int'(off) % m_bytes(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
        int n;
        n = m_bytes(f3);
        return 4'(((1 << n) - 1) << int'(off));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r;
        int n;
        n = m_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        int n;
        logic [31:0] mask;
        logic [31:0] v;
        n    = m_bytes(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        v    = (rd >> (8*int'(off))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver: one access plus a simple memory responder ----
    // Pulses start in cycle 0, then observes cycles 1..16. The responder
    // raises mem_ready on the (delay+1)-th cycle it sees mem_req, and drives
    // random mem_ready whenever there is no request.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int delay, input int restart_cyc);
        int          req_cnt;
        logic [68:0] v;
        o_saw_req = 0; o_req_vec = '0; o_stable = 1; o_busy1 = 0;
        o_done_cyc = -1; o_n_done = 0; o_fault = 0; o_lr = 0; req_cnt = 0;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        @(posedge clk); #1;
        for (int c = 1; c <= 16; c++) begin
            start = (c == restart_cyc);
            if (start) begin
                is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0700;
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                v = {mem_we, mem_addr, mem_wstrb, mem_wdata};
                if (req_cnt == 1) begin
                    o_saw_req = 1; o_req_vec = v;
                end else if (v !== o_req_vec) begin
                    o_stable = 0;
                end
                mem_ready = (req_cnt == delay + 1);
                mem_rdata = mem_ready ? rd : $urandom;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            @(negedge clk);
            if (c == 1) o_busy1 = busy;
            if (done === 1'b1) begin
                o_n_done++;
                if (o_done_cyc < 0) begin
                    o_done_cyc = c; o_fault = fault; o_lr = load_result;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_load = 0; is_store = 0; funct3 = 0;
        addr = 0; store_data = 0; mem_ready = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (load_result !== 32'h0) begin
            failures++; $display("FAIL reset_load_result: got %h expected %h", load_result, 32'h0);
        end
        checks++;
        if ({done, fault, busy, mem_req, mem_we} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected %b", {done, fault, busy, mem_req, mem_we}, 5'b0);
        end
        checks++;
        if ({mem_addr, mem_wstrb, mem_wdata} !== 68'h0) begin
            failures++; $display("FAIL reset_bus: got %h expected %h", {mem_addr, mem_wstrb, mem_wdata}, 68'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_lr = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb;
        run_access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, 0);
        checks++;
        if (o_req_vec !== {1'b0, 32'h0000_0100, 4'h0, 32'h0}) begin
            failures++; $display("FAIL lb_request: got %h expected %h", o_req_vec, {1'b0, 32'h0000_0100, 4'h0, 32'h0});
        end
        checks++;
        if (o_done_cyc !== 2) begin
            failures++; $display("FAIL lb_latency: got %0d expected %0d", o_done_cyc, 2);
        end
        checks++;
        if ({o_fault, o_lr} !== {1'b0, 32'hFFFF_FF80}) begin
            failures++; $display("FAIL lb_result: got %b/%h expected 0/%h", o_fault, o_lr, 32'hFFFF_FF80);
        end
        exp_lr = 32'hFFFF_FF80;
    endtask

    task automatic test_sh;
        run_access(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0);
        checks++;
        if (o_req_vec !== {1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD}) begin
            failures++; $display("FAIL sh_request: got %h expected %h", o_req_vec, {1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD});
        end
        checks++;
        if (o_stable !== 1'b1) begin
            failures++; $display("FAIL sh_stable: got %0d expected 1", o_stable);
        end
        checks++;
        if (o_done_cyc !== 5) begin
            failures++; $display("FAIL sh_latency: got %0d expected %0d", o_done_cyc, 5);
        end
        checks++;
        if (o_lr !== exp_lr) begin
            failures++; $display("FAIL sh_load_result_kept: got %h expected %h", o_lr, exp_lr);
        end
    endtask

    task automatic test_misaligned;
        run_access(1, 0, 3'b010, 32'h0000_0301, 32'h0, 32'hDEAD_BEEF, 0, 0);
        checks++;
        if (o_saw_req !== 1'b0) begin
            failures++; $display("FAIL lw_mis_no_req: got %0d expected 0", o_saw_req);
        end
        checks++;
        if ({o_done_cyc, o_fault} !== {32'd2, 1'b1}) begin
            failures++; $display("FAIL lw_mis_fault: got cyc %0d fault %b expected cyc 2 fault 1", o_done_cyc, o_fault);
        end
        checks++;
        if (o_lr !== exp_lr) begin
            failures++; $display("FAIL lw_mis_load_result: got %h expected %h", o_lr, exp_lr);
        end
    endtask

    task automatic test_half_ext;
        run_access(1, 0, 3'b101, 32'h0000_0402, 32'h0, 32'h9ABC_0000, 1, 0);
        checks++;
        if (o_lr !== 32'h0000_9ABC) begin
            failures++; $display("FAIL lhu_result: got %h expected %h", o_lr, 32'h0000_9ABC);
        end
        run_access(1, 0, 3'b001, 32'h0000_0402, 32'h0, 32'h9ABC_0000, 0, 0);
        checks++;
        if (o_lr !== 32'hFFFF_9ABC) begin
            failures++; $display("FAIL lh_result: got %h expected %h", o_lr, 32'hFFFF_9ABC);
        end
        exp_lr = 32'hFFFF_9ABC;
    endtask

    task automatic test_busy_restart;
        run_access(1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 3, 2);
        checks++;
        if ({o_n_done, o_done_cyc} !== {32'd1, 32'd5}) begin
            failures++; $display("FAIL restart_ignored: got dones %0d at %0d expected 1 at 5", o_n_done, o_done_cyc);
        end
        checks++;
        if (o_lr !== 32'h1357_9BDF) begin
            failures++; $display("FAIL restart_result: got %h expected %h", o_lr, 32'h1357_9BDF);
        end
        exp_lr = 32'h1357_9BDF;
    endtask

    task automatic test_ignored_and_illegal;
        run_access(0, 0, 3'b010, 32'h0000_0800, 32'h0, 32'h0, 0, 0);
        checks++;
        if ({o_n_done, o_saw_req, o_busy1} !== {32'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL no_op_ignored: got dones %0d req %0d busy %b expected 0 0 0", o_n_done, o_saw_req, o_busy1);
        end
        run_access(0, 1, 3'b100, 32'h0000_0900, 32'hFFFF_FFFF, 32'h0, 0, 0);
        checks++;
        if ({o_saw_req, o_done_cyc, o_fault} !== {1'b0, 32'd2, 1'b1}) begin
            failures++; $display("FAIL store_f3_100: got req %0d cyc %0d fault %b expected 0 2 1", o_saw_req, o_done_cyc, o_fault);
        end
    endtask

    task automatic test_random;
        logic        ld, st, ld_eff, legal;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd;
        int          dly;
        logic [68:0] exp_vec;
        int          exp_cyc;
        for (int it = 0; it < 40; it++) begin
            ld = 1'($urandom_range(0, 1));
            st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_eff = ld;
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom; sd = $urandom; rd = $urandom;
            dly = $urandom_range(0, 4);
            legal = m_legal(ld_eff, f3, a[1:0]);
            run_access(ld, st, f3, a, sd, rd, dly, 0);
            if (legal && ld_eff) exp_lr = m_load(f3, a[1:0], rd);
            exp_cyc = legal ? dly + 2 : 2;
            checks++;
            if ({o_n_done, o_done_cyc, o_fault} !== {32'd1, exp_cyc, !legal}) begin
                failures++; $display("FAIL rand_done[%0d]: got n %0d cyc %0d fault %b expected 1 %0d %b",
                                     it, o_n_done, o_done_cyc, o_fault, exp_cyc, !legal);
            end
            checks++;
            if (o_lr !== exp_lr) begin
                failures++; $display("FAIL rand_load_result[%0d]: got %h expected %h", it, o_lr, exp_lr);
            end
            exp_vec = {!ld_eff, a[31:2], 2'b00,
                       ld_eff ? 4'b0000 : m_strb(f3, a[1:0]),
                       ld_eff ? 32'h0 : m_wdata(f3, sd)};
            checks++;
            if (legal) begin
                if (o_saw_req !== 1'b1 || o_req_vec !== exp_vec || o_stable !== 1'b1) begin
                    failures++; $display("FAIL rand_request[%0d]: got req %0d vec %h stable %0d expected 1 %h 1",
                                         it, o_saw_req, o_req_vec, o_stable, exp_vec);
                end
            end else if (o_saw_req !== 1'b0) begin
                failures++; $display("FAIL rand_fault_no_req[%0d]: got req %0d expected 0", it, o_saw_req);
            end
        end
    endtask

    task automatic test_reset_mid_req;
        int n_done;
        n_done = 0;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_0500; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL mid_req_active: got %b expected 1", mem_req);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_req, busy, done, load_result} !== {3'b000, 32'h0}) begin
            failures++; $display("FAIL mid_req_reset: got req %b busy %b done %b lr %h expected 0 0 0 0",
                                 mem_req, busy, done, load_result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_lr = 32'h0;
        for (int c = 0; c < 6; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        checks++;
        if (n_done != 0) begin
            failures++; $display("FAIL mid_req_no_done: got %0d expected 0", n_done);
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_sh;
        test_misaligned;
        test_half_ext;
        test_busy_restart;
        test_ignored_and_illegal;
        test_random;
        test_reset_mid_req;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
